// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM-subset control unit.
package cpu_ctrl_pkg;

  // Controller states; S4..S6 are unused in this controller.
  typedef enum logic [4:0] {
    StIdle = 5'd0,
    StS0   = 5'd1,
    StS1   = 5'd2,
    StS2   = 5'd3,
    StS3   = 5'd4,
    StS7   = 5'd8,
    StS8   = 5'd9,
    StS9   = 5'd10,
    StS10  = 5'd11,
    StS11  = 5'd12,
    StS12  = 5'd13,
    StS13  = 5'd14,
    StS14  = 5'd15,
    StS15  = 5'd16
  } state_e;

  // Instruction classes; DP0/DP1/DP2 double as the shift-amount select code.
  typedef enum logic [2:0] {
    ClsDp0 = 3'd0,
    ClsDp1 = 3'd1,
    ClsDp2 = 3'd2,
    ClsLs  = 3'd3,
    ClsB   = 3'd4,
    ClsBl  = 3'd5,
    ClsBx  = 3'd6,
    ClsUnd = 3'd7
  } cls_e;

  localparam logic [3:0] AluAdd  = 4'b0100;
  localparam logic [3:0] AluSub  = 4'b0010;
  localparam logic [3:0] AluPass = 4'b1000;

  localparam logic [1:0] PcPlus4 = 2'b00;
  localparam logic [1:0] PcRm    = 2'b01;
  localparam logic [1:0] PcF     = 2'b10;

  localparam logic [1:0] RdRd  = 2'b00;
  localparam logic [1:0] RdR14 = 2'b01;
  localparam logic [1:0] RdRn  = 2'b10;

  // All datapath control lines, registered as one word.
  typedef struct packed {
    logic       write_pc;
    logic       write_ir;
    logic       write_reg;
    logic       la;
    logic       lb;
    logic       lc;
    logic       lf;
    logic       s;
    logic       rm_imm_s;
    logic [1:0] rs_imm_s;
    logic       off_s;
    logic [3:0] alu_op;
    logic [1:0] pc_s;
    logic [1:0] rd_s;
    logic       alu_a_s;
    logic       alu_b_s;
    logic       wdata_s;
    logic       addr_s;
    logic       mem_read;
    logic       mem_write;
    logic       ld;
    logic       mem_err;
  } ctrl_t;

  // TST/TEQ/CMP/CMN (10xx) reuse AND/EOR/SUB/ADD; everything else passes OP through.
  function automatic logic [3:0] dp_alu_op(input logic [3:0] op);
    if (op[3:2] == 2'b10) begin
      return 4'b1000 >> (3'd4 - {1'b0, op[1:0]});
    end
    return op;
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Instruction class and load/store field decode of the current IR.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output cls_e        cls_o,
  output logic        p_o,
  output logic        u_o,
  output logic        l_o,
  output logic        wb_o
);

  logic unused_bits;
  assign unused_bits = ^{instr_i[31:28], instr_i[3:0]};

  // Classify on the major opcode bits I[27:25].
  always_comb begin
    cls_o = ClsUnd;
    unique case (instr_i[27:25])
      3'b000: begin
        if (instr_i[24:4] == 21'h12FFF1) cls_o = ClsBx;
        else if (!instr_i[4])            cls_o = ClsDp0;
        else if (!instr_i[7])            cls_o = ClsDp1;
        else                             cls_o = ClsUnd;
      end
      3'b001:  cls_o = ClsDp2;
      3'b010:  cls_o = ClsLs;
      3'b011:  cls_o = instr_i[4] ? ClsUnd : ClsLs;
      3'b101:  cls_o = instr_i[24] ? ClsBl : ClsB;
      default: cls_o = ClsUnd;
    endcase
  end

  assign p_o  = instr_i[24];
  assign u_o  = instr_i[23];
  assign l_o  = instr_i[20];
  // Post-index always writes the base back.
  assign wb_o = !instr_i[24] | instr_i[21];

endmodule

// File: rtl/cpu_ctrl_ldst.sv
// Multicycle control unit: fetch/decode/execute/writeback for DP, branch and LDR/STR.
module cpu_ctrl_ldst
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned WAIT_W      = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [31:0]      I,
  input  logic             flag,
  input  logic             mem_ready,
  output logic             Write_PC,
  output logic             Write_IR,
  output logic             Write_Reg,
  output logic             LA,
  output logic             LB,
  output logic             LC,
  output logic             LF,
  output logic             S,
  output logic             rm_imm_s,
  output logic [1:0]       rs_imm_s,
  output logic             Off_s,
  output logic [3:0]       ALU_OP,
  output logic [1:0]       PC_s,
  output logic [1:0]       rd_s,
  output logic             ALU_A_s,
  output logic             ALU_B_s,
  output logic             Wdata_s,
  output logic             Addr_s,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic             LD,
  output logic             Mem_err,
  output logic [CNT_W-1:0] Inst_cnt
);

  localparam bit TimeoutEn = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WaitLast = TimeoutEn ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_e            st_q, st_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              retire, timeout;

  cls_e       cls;
  logic       p, u, l, wb;
  logic [3:0] op;

  assign op = I[24:21];

  cpu_ctrl_decode u_decode (
    .instr_i (I),
    .cls_o   (cls),
    .p_o     (p),
    .u_o     (u),
    .l_o     (l),
    .wb_o    (wb)
  );

  // Next state, plus retire/timeout events taken on this transition.
  always_comb begin
    st_d    = st_q;
    retire  = 1'b0;
    timeout = 1'b0;
    unique case (st_q)
      StIdle: st_d = StS0;
      StS0: begin
        if (flag && cls != ClsUnd) begin
          if (cls == ClsB)       st_d = StS8;
          else if (cls == ClsBl) st_d = StS10;
          else                   st_d = StS1;
        end
      end
      StS1: begin
        if (cls == ClsBx)      st_d = StS7;
        else if (cls == ClsLs) st_d = StS12;
        else                   st_d = StS2;
      end
      StS2:  st_d = StS3;
      StS3:  begin st_d = StS0; retire = 1'b1; end
      StS7:  begin st_d = StS0; retire = 1'b1; end
      StS8:  st_d = StS9;
      StS9:  begin st_d = StS0; retire = 1'b1; end
      StS10: st_d = StS11;
      StS11: st_d = StS9;
      StS12: st_d = StS13;
      StS13: begin
        if (mem_ready) begin
          if (l)       st_d = StS14;
          else if (wb) st_d = StS15;
          else begin
            st_d   = StS0;
            retire = 1'b1;
          end
        end else if (TimeoutEn && wait_q == WaitLast) begin
          st_d    = StS0;
          timeout = 1'b1;
        end
      end
      StS14: begin
        if (wb) st_d = StS15;
        else begin
          st_d   = StS0;
          retire = 1'b1;
        end
      end
      StS15:   begin st_d = StS0; retire = 1'b1; end
      default: st_d = StIdle;
    endcase
  end

  // Control lines decoded from the state being entered, so they are registered with it.
  always_comb begin
    ctrl_d = '0;
    unique case (st_d)
      StS0: begin
        ctrl_d.write_pc = 1'b1;
        ctrl_d.write_ir = 1'b1;
      end
      StS1: begin
        ctrl_d.la = 1'b1;
        ctrl_d.lb = 1'b1;
        ctrl_d.lc = 1'b1;
      end
      StS2: begin
        ctrl_d.lf       = 1'b1;
        ctrl_d.s        = I[20];
        ctrl_d.rm_imm_s = (cls == ClsDp2);
        ctrl_d.rs_imm_s = (cls == ClsDp1) ? 2'b01 : (cls == ClsDp2) ? 2'b10 : 2'b00;
        ctrl_d.alu_op   = dp_alu_op(op);
      end
      StS3: ctrl_d.write_reg = !op[3] | op[2];
      StS7: begin
        ctrl_d.write_pc = 1'b1;
        ctrl_d.pc_s     = PcRm;
      end
      StS8: begin
        ctrl_d.lf      = 1'b1;
        ctrl_d.alu_a_s = 1'b1;
        ctrl_d.alu_b_s = 1'b1;
        ctrl_d.alu_op  = AluAdd;
      end
      StS9: begin
        ctrl_d.write_pc = 1'b1;
        ctrl_d.pc_s     = PcF;
      end
      StS10: begin
        ctrl_d.lf      = 1'b1;
        ctrl_d.alu_a_s = 1'b1;
        ctrl_d.alu_op  = AluPass;
      end
      StS11: begin
        ctrl_d.write_reg = 1'b1;
        ctrl_d.rd_s      = RdR14;
        ctrl_d.lf        = 1'b1;
        ctrl_d.alu_a_s   = 1'b1;
        ctrl_d.alu_b_s   = 1'b1;
        ctrl_d.alu_op    = AluAdd;
      end
      StS12: begin
        ctrl_d.lf     = 1'b1;
        ctrl_d.alu_op = u ? AluAdd : AluSub;
        ctrl_d.off_s  = !I[25];
      end
      StS13: begin
        ctrl_d.mem_read  = l;
        ctrl_d.mem_write = !l;
        ctrl_d.ld        = l;
        ctrl_d.addr_s    = p;
      end
      StS14: begin
        ctrl_d.write_reg = 1'b1;
        ctrl_d.rd_s      = RdRd;
        ctrl_d.wdata_s   = 1'b1;
      end
      StS15: begin
        ctrl_d.write_reg = 1'b1;
        ctrl_d.rd_s      = RdRn;
      end
      default: ;
    endcase
    ctrl_d.mem_err = timeout;
  end

  // State, registered controls, memory wait counter and retired-instruction count.
  always_ff @(posedge clk) begin
    if (Rst) begin
      st_q   <= StIdle;
      ctrl_q <= '0;
      wait_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      ctrl_q <= ctrl_d;
      if (st_d == StS13 && st_q != StS13) begin
        wait_q <= '0;
      end else if (st_q == StS13 && !mem_ready && wait_q != '1) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign Write_PC  = ctrl_q.write_pc;
  assign Write_IR  = ctrl_q.write_ir;
  assign Write_Reg = ctrl_q.write_reg;
  assign LA        = ctrl_q.la;
  assign LB        = ctrl_q.lb;
  assign LC        = ctrl_q.lc;
  assign LF        = ctrl_q.lf;
  assign S         = ctrl_q.s;
  assign rm_imm_s  = ctrl_q.rm_imm_s;
  assign rs_imm_s  = ctrl_q.rs_imm_s;
  assign Off_s     = ctrl_q.off_s;
  assign ALU_OP    = ctrl_q.alu_op;
  assign PC_s      = ctrl_q.pc_s;
  assign rd_s      = ctrl_q.rd_s;
  assign ALU_A_s   = ctrl_q.alu_a_s;
  assign ALU_B_s   = ctrl_q.alu_b_s;
  assign Wdata_s   = ctrl_q.wdata_s;
  assign Addr_s    = ctrl_q.addr_s;
  assign Mem_Read  = ctrl_q.mem_read;
  assign Mem_Write = ctrl_q.mem_write;
  assign LD        = ctrl_q.ld;
  assign Mem_err   = ctrl_q.mem_err;
  assign Inst_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_ldst.sv
// Directed bench for cpu_ctrl_ldst: checks the full control word every cycle of each sequence.
module tb_cpu_ctrl_ldst;

  logic        clk;
  logic        Rst;
  logic [31:0] I;
  logic        flag;
  logic        mem_ready;
  logic        Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S, rm_imm_s, Off_s;
  logic [1:0]  rs_imm_s, PC_s, rd_s;
  logic [3:0]  ALU_OP;
  logic        ALU_A_s, ALU_B_s, Wdata_s, Addr_s, Mem_Read, Mem_Write, LD, Mem_err;
  logic [15:0] Inst_cnt;

  cpu_ctrl_ldst u_dut (
    .clk       (clk),
    .Rst       (Rst),
    .I         (I),
    .flag      (flag),
    .mem_ready (mem_ready),
    .Write_PC  (Write_PC),
    .Write_IR  (Write_IR),
    .Write_Reg (Write_Reg),
    .LA        (LA),
    .LB        (LB),
    .LC        (LC),
    .LF        (LF),
    .S         (S),
    .rm_imm_s  (rm_imm_s),
    .rs_imm_s  (rs_imm_s),
    .Off_s     (Off_s),
    .ALU_OP    (ALU_OP),
    .PC_s      (PC_s),
    .rd_s      (rd_s),
    .ALU_A_s   (ALU_A_s),
    .ALU_B_s   (ALU_B_s),
    .Wdata_s   (Wdata_s),
    .Addr_s    (Addr_s),
    .Mem_Read  (Mem_Read),
    .Mem_Write (Mem_Write),
    .LD        (LD),
    .Mem_err   (Mem_err),
    .Inst_cnt  (Inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control word, one bit/field per output.
  logic [27:0] ctl;
  assign ctl = {Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S, rm_imm_s, rs_imm_s, Off_s,
                ALU_OP, PC_s, rd_s, ALU_A_s, ALU_B_s, Wdata_s, Addr_s, Mem_Read, Mem_Write,
                LD, Mem_err};

  localparam logic [27:0] WPC  = 28'd1 << 27;
  localparam logic [27:0] WIR  = 28'd1 << 26;
  localparam logic [27:0] WREG = 28'd1 << 25;
  localparam logic [27:0] LAB  = 28'd1 << 24;
  localparam logic [27:0] LBB  = 28'd1 << 23;
  localparam logic [27:0] LCB  = 28'd1 << 22;
  localparam logic [27:0] LFB  = 28'd1 << 21;
  localparam logic [27:0] SB   = 28'd1 << 20;
  localparam logic [27:0] RMI  = 28'd1 << 19;
  localparam logic [27:0] OFF  = 28'd1 << 16;
  localparam logic [27:0] AA   = 28'd1 << 7;
  localparam logic [27:0] AB   = 28'd1 << 6;
  localparam logic [27:0] WD   = 28'd1 << 5;
  localparam logic [27:0] AD   = 28'd1 << 4;
  localparam logic [27:0] MR   = 28'd1 << 3;
  localparam logic [27:0] MW   = 28'd1 << 2;
  localparam logic [27:0] LDB  = 28'd1 << 1;
  localparam logic [27:0] ERR  = 28'd1;

  localparam logic [27:0] FETCH = WPC | WIR;
  localparam logic [27:0] REGRD = LAB | LBB | LCB;

  localparam logic [31:0] IAdd  = 32'hE0821003;
  localparam logic [31:0] ICmp  = 32'hE3510005;
  localparam logic [31:0] ILdr  = 32'hE5B10004;
  localparam logic [31:0] IStr  = 32'hE4010008;
  localparam logic [31:0] IBl   = 32'hEB000002;
  localparam logic [31:0] IUnd  = 32'hE6000010;

  function automatic logic [27:0] alu(input logic [3:0] v);
    return {12'd0, v, 12'd0};
  endfunction
  function automatic logic [27:0] rss(input logic [1:0] v);
    return {9'd0, v, 17'd0};
  endfunction
  function automatic logic [27:0] pcs(input logic [1:0] v);
    return {16'd0, v, 10'd0};
  endfunction
  function automatic logic [27:0] rds(input logic [1:0] v);
    return {18'd0, v, 8'd0};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare the control word just after the edge.
  task automatic cyc(input string tag, input logic [27:0] exp);
    @(posedge clk);
    #1;
    check_eq(tag, {4'd0, ctl}, {4'd0, exp});
  endtask

  initial begin
    Rst       = 1'b1;
    I         = 32'd0;
    flag      = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctl", {4'd0, ctl}, 32'd0);
    check_eq("rst_cnt", {16'd0, Inst_cnt}, 32'd0);

    // ADD r1,r2,r3
    I    = IAdd;
    flag = 1'b1;
    Rst  = 1'b0;
    cyc("add_s0", FETCH);
    check_eq("add_cnt0", {16'd0, Inst_cnt}, 32'd0);
    cyc("add_s1", REGRD);
    cyc("add_s2", LFB | alu(4'b0100));
    cyc("add_s3", WREG);
    cyc("add_fetch", FETCH);
    check_eq("add_cnt", {16'd0, Inst_cnt}, 32'd1);

    // CMP r1,#5: immediate rotate, S set, no register write, SUB
    I = ICmp;
    cyc("cmp_s1", REGRD);
    cyc("cmp_s2", LFB | SB | RMI | rss(2'b10) | alu(4'b0010));
    cyc("cmp_s3", 28'd0);
    cyc("cmp_fetch", FETCH);
    check_eq("cmp_cnt", {16'd0, Inst_cnt}, 32'd2);

    // LDR r0,[r1,#4]! with ready in the third memory cycle
    I = ILdr;
    cyc("ldr_s1", REGRD);
    cyc("ldr_s12", LFB | OFF | alu(4'b0100));
    for (int i = 0; i < 3; i++) begin
      cyc("ldr_s13", MR | LDB | AD);
      if (i == 2) mem_ready = 1'b1;
    end
    cyc("ldr_s14", WREG | rds(2'b00) | WD);
    mem_ready = 1'b0;
    cyc("ldr_s15", WREG | rds(2'b10));
    cyc("ldr_fetch", FETCH);
    check_eq("ldr_cnt", {16'd0, Inst_cnt}, 32'd3);

    // STR r0,[r1],#-8 with immediate ready
    I         = IStr;
    mem_ready = 1'b1;
    cyc("str_s1", REGRD);
    cyc("str_s12", LFB | OFF | alu(4'b0010));
    cyc("str_s13", MW);
    cyc("str_s15", WREG | rds(2'b10));
    mem_ready = 1'b0;
    cyc("str_fetch", FETCH);
    check_eq("str_cnt", {16'd0, Inst_cnt}, 32'd4);

    // STR with no ready: 15 write cycles, then abort with an error pulse
    cyc("to_s1", REGRD);
    cyc("to_s12", LFB | OFF | alu(4'b0010));
    for (int i = 0; i < 15; i++) cyc("to_s13", MW);
    cyc("to_err", FETCH | ERR);
    check_eq("to_cnt", {16'd0, Inst_cnt}, 32'd4);

    // BL
    I = IBl;
    cyc("bl_s10", LFB | AA | alu(4'b1000));
    cyc("bl_s11", WREG | rds(2'b01) | LFB | AA | AB | alu(4'b0100));
    cyc("bl_s9", WPC | pcs(2'b10));
    cyc("bl_fetch", FETCH);
    check_eq("bl_cnt", {16'd0, Inst_cnt}, 32'd5);

    // BL failing its condition: refetch, not counted
    flag = 1'b0;
    cyc("nf_s0a", FETCH);
    cyc("nf_s0b", FETCH);
    check_eq("nf_cnt", {16'd0, Inst_cnt}, 32'd5);

    // Undefined instruction: refetch
    flag = 1'b1;
    I    = IUnd;
    cyc("und_s0a", FETCH);
    cyc("und_s0b", FETCH);
    check_eq("und_cnt", {16'd0, Inst_cnt}, 32'd5);

    // Reset while a load is waiting in the memory state
    I = ILdr;
    cyc("rs_s1", REGRD);
    cyc("rs_s12", LFB | OFF | alu(4'b0100));
    cyc("rs_s13", MR | LDB | AD);
    Rst = 1'b1;
    cyc("rs_clear", 28'd0);
    check_eq("rs_cnt", {16'd0, Inst_cnt}, 32'd0);
    Rst = 1'b0;
    cyc("rs_s0", FETCH);
    cyc("rs_s1b", REGRD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
